// File: rtl/lzrw_ingest_window_pkg.sv
`default_nettype none
// ============================================================================
//  lzrw_pkg
//  Shared types and constants for the LZRW1 ingest window.
//  Revision: 1.0
// ============================================================================
package lzrw_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] pos_t;

    localparam int MIN_MATCH = 3;
    localparam int MAX_MATCH = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lzrw_ingest_window_if.sv
`default_nettype none
// ============================================================================
//  lzrw_ingest_window_if
//  Beat input and lookahead-window output bundle of the ingest stage.
//  Revision: 1.0
// ============================================================================
interface lzrw_ingest_window_if #(
    parameter int LANES = 16,
    parameter int WIN   = 18,
    parameter int POSW  = 16
);
    localparam int CNTW = $clog2(LANES + 1);
    localparam int AVW  = $clog2(WIN + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*8-1:0]   in_bytes;
    logic [CNTW-1:0]      in_count;
    logic                 in_last;
    logic                 out_valid;
    logic [WIN*8-1:0]     out_bytes;
    logic [AVW-1:0]       out_avail;
    logic [POSW-1:0]      out_pos;
    logic                 adv;
    logic [4:0]           adv_len;
    logic                 done;

    modport master (
        output in_valid, in_bytes, in_count, in_last, adv, adv_len,
        input  in_ready, out_valid, out_bytes, out_avail, out_pos, done
    );

    modport slave (
        input  in_valid, in_bytes, in_count, in_last, adv, adv_len,
        output in_ready, out_valid, out_bytes, out_avail, out_pos, done
    );

endinterface
`default_nettype wire

// File: rtl/lzrw_ingest_window_ring.sv
`default_nettype none
// ============================================================================
//  lzrw_byte_ring
//  Circular byte store: LANES-wide masked write, WIN-wide wrapped read.
//  Revision: 1.0
// ============================================================================
module lzrw_byte_ring
    import lzrw_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LANES = 16,
    parameter int WIN   = 18,
    localparam int PTRW = $clog2(DEPTH),
    localparam int CNTW = $clog2(LANES + 1)
) (
    input  wire logic               clock,
    input  wire logic               i_wrEn,
    input  wire logic [PTRW-1:0]    i_wrPtr,
    input  wire logic [CNTW-1:0]    i_wrCount,
    input  wire logic [LANES*8-1:0] i_wrBytes,
    input  wire logic [PTRW-1:0]    i_rdPtr,
    output logic      [WIN*8-1:0]   o_rdBytes
);

    byte_t r_mem [DEPTH];

    // Power-of-two depth lets pointer overflow do the wrap.
    always_ff @(posedge clock) begin
        for (int l = 0; l < LANES; l++) begin
            if (i_wrEn && (l < int'(i_wrCount)))
                r_mem[PTRW'(i_wrPtr + PTRW'(l))] <= i_wrBytes[l*8 +: 8];
        end
    end

    generate
        for (genvar w = 0; w < WIN; w++) begin : g_rd
            assign o_rdBytes[w*8 +: 8] = r_mem[PTRW'(i_rdPtr + PTRW'(w))];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lzrw_ingest_window.sv
`default_nettype none
// ============================================================================
//  lzrw_ingest_window
//  Beat-to-window ingest stage with backpressure and block tracking.
//  Optional feature macro: ZERO_TERM_EN (first 0x00 lane ends the block).
//  Revision: 1.0
// ============================================================================
module lzrw_ingest_window
    import lzrw_pkg::*;
#(
    parameter int LANES = 16,
    parameter int DEPTH = 64,
    parameter int WIN   = MAX_MATCH,
    parameter int POSW  = 16
) (
    input  wire logic           clock,
    input  wire logic           reset,
    lzrw_ingest_window_if.slave bus
);

    localparam int c_PTRW = $clog2(DEPTH);
    localparam int c_OCCW = $clog2(DEPTH + 1);
    localparam int c_CNTW = $clog2(LANES + 1);
    localparam int c_AVW  = $clog2(WIN + 1);

    state_t              r_state, w_stateNext;
    logic [c_OCCW-1:0]   r_occ, w_occNext, w_cnt, w_advLen, w_avail;
    logic [c_PTRW-1:0]   r_wrPtr, r_rdPtr;
    logic [POSW-1:0]     r_pos;
    logic                r_inReady, w_accept, w_last, w_valid, w_advEff;
    logic [c_CNTW-1:0]   w_count;
    logic [WIN*8-1:0]    w_ringBytes, w_window;

    assign w_accept = bus.in_valid && r_inReady;

`ifdef ZERO_TERM_EN
    // Descending scan leaves the lowest zero lane as the truncation point.
    always_comb begin
        w_count = bus.in_count;
        w_last  = bus.in_last;
        for (int l = LANES - 1; l >= 0; l--) begin
            if ((l < int'(bus.in_count)) && (bus.in_bytes[l*8 +: 8] == 8'h00)) begin
                w_count = c_CNTW'(l);
                w_last  = 1'b1;
            end
        end
    end
`else
    assign w_count = bus.in_count;
    assign w_last  = bus.in_last;
`endif

    assign w_cnt    = w_accept ? c_OCCW'(w_count) : '0;
    assign w_avail  = (r_occ >= c_OCCW'(WIN)) ? c_OCCW'(WIN) : r_occ;
    assign w_valid  = (r_occ >= c_OCCW'(WIN)) || ((r_state == DRAIN) && (r_occ != '0));
    assign w_advEff = bus.adv && w_valid;

    always_comb begin
        w_advLen = '0;
        if (w_advEff) begin
            if ((bus.adv_len == 5'd0) || (c_OCCW'(bus.adv_len) > w_avail))
                w_advLen = w_avail;
            else
                w_advLen = c_OCCW'(bus.adv_len);
        end
    end

    assign w_occNext = r_occ + w_cnt - w_advLen;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    w_stateNext = FILL;
            FILL:    if (w_accept && w_last) w_stateNext = DRAIN;
            DRAIN:   if (w_occNext == '0) w_stateNext = DONE;
            DONE:    w_stateNext = FILL;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_occ     <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_pos     <= '0;
            r_inReady <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_occ     <= w_occNext;
            r_wrPtr   <= r_wrPtr + c_PTRW'(w_cnt);
            r_rdPtr   <= r_rdPtr + c_PTRW'(w_advLen);
            r_inReady <= (w_stateNext == FILL) &&
                         ((c_OCCW'(DEPTH) - w_occNext) >= c_OCCW'(LANES));
            if (r_state == DONE)
                r_pos <= '0;
            else
                r_pos <= r_pos + POSW'(w_advLen);
        end
    end

    lzrw_byte_ring #(
        .DEPTH (DEPTH),
        .LANES (LANES),
        .WIN   (WIN)
    ) u_ring (
        .clock     (clock),
        .i_wrEn    (w_accept && (w_count != '0)),
        .i_wrPtr   (r_wrPtr),
        .i_wrCount (w_count),
        .i_wrBytes (bus.in_bytes),
        .i_rdPtr   (r_rdPtr),
        .o_rdBytes (w_ringBytes)
    );

    always_comb begin
        w_window = '0;
        for (int w = 0; w < WIN; w++) begin
            if (c_OCCW'(w) < w_avail)
                w_window[w*8 +: 8] = w_ringBytes[w*8 +: 8];
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = w_valid;
    assign bus.out_bytes = w_window;
    assign bus.out_avail = c_AVW'(w_avail);
    assign bus.out_pos   = r_pos;
    assign bus.done      = (r_state == DONE);

    a_advLegal: assert property (@(posedge clock) disable iff (!reset)
        w_advEff |-> ((bus.adv_len != 5'd0) && (c_OCCW'(bus.adv_len) <= w_avail)));

endmodule
`default_nettype wire

// File: tb/tb_lzrw_ingest_window.sv
`default_nettype none
// ============================================================================
//  tb_lzrw_ingest_window
//  Scoreboard bench: byte-queue reference model predicts every output cycle.
//  Revision: 1.0
// ============================================================================
module tb_lzrw_ingest_window;

    localparam int LANES = 16;
    localparam int DEPTH = 64;
    localparam int WIN   = 18;
    localparam int POSW  = 16;

    typedef struct packed {
        logic             valid;
        logic             ready;
        logic             done;
        logic [4:0]       avail;
        logic [15:0]      pos;
        logic [WIN*8-1:0] bytes;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    lzrw_ingest_window_if #(.LANES(LANES), .WIN(WIN), .POSW(POSW)) bus();

    lzrw_ingest_window #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .WIN   (WIN),
        .POSW  (POSW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: bytes currently held, block phase (0 idle, 1 fill, 2 drain, 3 done).
    logic [7:0] mq[$];
    int         phase = 0;
    int         mpos  = 0;
    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [WIN*8-1:0] act, input logic [WIN*8-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   n;
        n       = (mq.size() < WIN) ? mq.size() : WIN;
        e.valid = (mq.size() >= WIN) || (phase == 2 && mq.size() > 0);
        e.ready = (phase == 1) && (DEPTH - mq.size() >= LANES);
        e.done  = (phase == 3);
        e.avail = 5'(n);
        e.pos   = 16'(mpos);
        e.bytes = '0;
        for (int w = 0; w < n; w++) e.bytes[w*8 +: 8] = mq[w];
        return e;
    endfunction

    // One clock cycle: record expectation, drive inputs, advance the model past the edge.
    task automatic step(input logic v, input logic [LANES*8-1:0] b, input int cnt,
                        input logic last, input logic a, input int alen);
        exp_t e;
        int   n;
        int   old;
        logic lst;
        logic hit;
        e = model_out();
        expq.push_back(e);
        bus.in_valid = v;
        bus.in_bytes = b;
        bus.in_count = 5'(cnt);
        bus.in_last  = last;
        bus.adv      = a;
        bus.adv_len  = 5'(alen);
        old = phase;
        lst = 1'b0;
        if (v && e.ready) begin
            n   = cnt;
            lst = last;
            hit = 1'b0;
`ifdef ZERO_TERM_EN
            for (int l = 0; l < cnt; l++) begin
                if (!hit && b[l*8 +: 8] == 8'h00) begin
                    hit = 1'b1;
                    n   = l;
                    lst = 1'b1;
                end
            end
`endif
            for (int l = 0; l < n; l++) mq.push_back(b[l*8 +: 8]);
        end
        if (a && e.valid) begin
            for (int k = 0; k < alen; k++) void'(mq.pop_front());
            mpos = (mpos + alen) % (1 << POSW);
        end
        case (old)
            0: phase = 1;
            1: if (v && e.ready && lst) phase = 2;
            2: if (mq.size() == 0) phase = 3;
            default: begin phase = 1; mpos = 0; end
        endcase
        @(posedge clock);
        #1;
    endtask

    task automatic rand_step(input int pIn, input int pLast, input int pAdv);
        exp_t                e;
        logic [LANES*8-1:0]  b;
        int                  cnt, alen, zl;
        logic                a;
        e = model_out();
        for (int l = 0; l < LANES; l++) b[l*8 +: 8] = 8'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            zl = $urandom_range(0, LANES - 1);
            b[zl*8 +: 8] = 8'h00;
        end
        cnt  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, LANES) : LANES;
        a    = 1'b0;
        alen = $urandom_range(1, WIN);
        if (e.valid) begin
            if ($urandom_range(0, 99) < pAdv) begin
                a    = 1'b1;
                alen = $urandom_range(1, int'(e.avail));
            end
        end else begin
            a = 1'($urandom_range(0, 1));
        end
        step($urandom_range(0, 99) < pIn, b, cnt, $urandom_range(0, 99) < pLast, a, alen);
    endtask

    // Close whatever block is open and settle in FILL with an empty ring.
    task automatic to_clean_fill();
        exp_t e;
        int   guard;
        guard = 0;
        while (!(phase == 1 && mq.size() == 0) && guard < 300) begin
            e = model_out();
            step(phase == 1, {LANES{8'h5A}}, 1, 1'b1, e.valid, e.valid ? int'(e.avail) : 1);
            guard++;
        end
        check("clean_fill_bound", 144'(guard < 300), 144'(1));
    endtask

    task automatic apply_reset(input int hold);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.adv      = 1'b0;
        mq.delete();
        phase = 0;
        mpos  = 0;
        repeat (hold) begin
            expq.push_back(model_out());
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
    endtask

    // Monitor: compares every cycle for which an expectation was recorded.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("out_valid", 144'(bus.out_valid), 144'(e.valid));
                check("in_ready",  144'(bus.in_ready),  144'(e.ready));
                check("done",      144'(bus.done),      144'(e.done));
                check("out_avail", 144'(bus.out_avail), 144'(e.avail));
                check("out_pos",   144'(bus.out_pos),   144'(e.pos));
                check("out_bytes", bus.out_bytes,       e.bytes);
            end
        end
    end

    initial begin
        logic [LANES*8-1:0] b;
        string              s;
        exp_t               e;
        int                 guard;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bytes = '0;
        bus.in_count = 5'd1;
        bus.in_last  = 1'b0;
        bus.adv      = 1'b0;
        bus.adv_len  = 5'd1;
        @(posedge clock);
        #1;
        apply_reset(2);
        step(1'b0, '0, 16, 1'b0, 1'b0, 1);

        // Single last beat walked one byte per cycle.
        s = "daddy finger dad";
        for (int l = 0; l < LANES; l++) b[l*8 +: 8] = s[l];
        step(1'b1, b, 16, 1'b1, 1'b0, 1);
        repeat (16) step(1'b0, '0, 16, 1'b0, 1'b1, 1);
        to_clean_fill();

        // Backpressure with no consumer, then resume.
        repeat (6) begin
            for (int l = 0; l < LANES; l++) b[l*8 +: 8] = 8'($urandom_range(1, 255));
            step(1'b1, b, 16, 1'b0, 1'b0, 1);
        end
        to_clean_fill();

        // Same-cycle accept and advance at occupancy 20.
        for (int l = 0; l < LANES; l++) b[l*8 +: 8] = 8'(8'h30 + l);
        step(1'b1, b, 16, 1'b0, 1'b0, 1);
        step(1'b1, b, 4, 1'b0, 1'b0, 1);
        step(1'b1, b, 16, 1'b0, 1'b1, 5);
        step(1'b0, b, 16, 1'b0, 1'b0, 1);
        to_clean_fill();

        // Short tail: 7 bytes consumed as 5 then 2.
        for (int l = 0; l < LANES; l++) b[l*8 +: 8] = 8'(8'h41 + l);
        step(1'b1, b, 7, 1'b1, 1'b0, 1);
        step(1'b0, b, 7, 1'b0, 1'b1, 5);
        step(1'b0, b, 7, 1'b0, 1'b1, 2);
        repeat (3) step(1'b0, b, 7, 1'b0, 1'b0, 1);

        // Zero byte at lane 9.
        b[9*8 +: 8] = 8'h00;
        step(1'b1, b, 16, 1'b0, 1'b0, 1);
        step(1'b0, b, 16, 1'b0, 1'b0, 1);
        to_clean_fill();

        repeat (2500) rand_step(70, 8, 60);

        // Reset while draining.
        guard = 0;
        while (!(phase == 2 && mq.size() > 0) && guard < 2000) begin
            rand_step(80, 30, 15);
            guard++;
        end
        check("reach_drain_bound", 144'(guard < 2000), 144'(1));
        apply_reset(3);
        repeat (200) rand_step(70, 8, 60);

        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", 144'(expq.size()), 144'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
